// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Controller FSM states and architectural register constants.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detect: load in EX feeding a source of the ID instruction.
// Writes to x0 are discarded, so they never create a dependency.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       memread_id_ex,
    input  logic [4:0] rd_id_ex,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    output logic       hazard
);

    logic rd_live;
    logic rs_match;

    assign rd_live  = rd_id_ex != REG_X0;
    assign rs_match = (rd_id_ex == rs1_id) | (rd_id_ex == rs2_id);
    assign hazard   = memread_id_ex & rd_live & rs_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: merges stall/flush causes into
// per-stage enables and flushes, with wait FSM, watchdog and stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memread_id_ex,
    input  logic [4:0]       rd_id_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             err_timeout
);

    localparam int unsigned WC_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(WAIT_LIMIT);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [1:0]      ret_state;
    logic [1:0]      ret_nxt;
    logic [1:0]      eff;
    logic            mdu_pend;
    logic            pend_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;

    logic in_mem;
    logic stall_all;
    logic mdu_busy;
    logic load_use;
    logic sel_mem;
    logic sel_br;
    logic sel_mdu;
    logic sel_imem;
    logic sel_lu;

    load_use_detect u_lud (
        .memread_id_ex (memread_id_ex),
        .rd_id_ex      (rd_id_ex),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .hazard        (load_use)
    );

    // On dmem_ready in MEM_WAIT the saved state's rules apply this same cycle.
    always_comb begin
        in_mem    = state == ST_MEM_WAIT;
        eff       = in_mem ? ret_state : state;
        stall_all = in_mem ? !dmem_ready : (dmem_req & !dmem_ready);
        mdu_busy  = ((eff == ST_RUN) & mdu_start & !mdu_done)
                  | ((eff == ST_MDU_WAIT) & !mdu_done & !mdu_pend);

        sel_mem  = stall_all;
        sel_br   = !stall_all & branch_taken;
        sel_mdu  = !stall_all & !branch_taken & mdu_busy;
        sel_imem = !stall_all & !branch_taken & !mdu_busy & !imem_ready;
        sel_lu   = !stall_all & !branch_taken & !mdu_busy & imem_ready
                 & load_use;

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        state_nxt    = ST_RUN;
        ret_nxt      = ret_state;
        pend_nxt     = 1'b0;

        unique case (1'b1)
            sel_mem: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                state_nxt = ST_MEM_WAIT;
                // A MUL/DIV caught behind the memory stall resumes its wait afterwards.
                if (!in_mem) begin
                    ret_nxt = mdu_busy ? ST_MDU_WAIT : ST_RUN;
                end
                pend_nxt  = mdu_pend | (in_mem & mdu_done);
            end
            sel_br: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            sel_mdu: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                flush_ex_mem = 1'b1;
                state_nxt    = ST_MDU_WAIT;
            end
            sel_imem: begin
                pc_en       = 1'b0;
                flush_if_id = 1'b1;
            end
            sel_lu: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                flush_id_ex = 1'b1;
            end
            default: ;
        endcase

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end

        if (state_nxt == ST_RUN) begin
            wait_nxt = '0;
        end else if (state != ST_RUN && wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + WC_W'(1);
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            ret_state    <= ST_RUN;
            mdu_pend     <= 1'b0;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ret_state   <= ret_nxt;
            mdu_pend    <= pend_nxt;
            wait_cnt    <= wait_nxt;
            err_timeout <= err_timeout | (wait_nxt == WAIT_MAX);
            if (!pc_en) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard, branch, MDU and memory wait
// sequences with hand-computed enable/flush vectors and counters.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread_id_ex;
    logic [4:0]  rd_id_ex;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        mdu_start;
    logic        mdu_done;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem}
    logic [7:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  flush_if_id, flush_id_ex, flush_ex_mem};

    localparam logic [7:0] V_RST  = 8'b0111_1111;
    localparam logic [7:0] V_RUN  = 8'b1111_1000;
    localparam logic [7:0] V_LU   = 8'b0011_1010;
    localparam logic [7:0] V_BR   = 8'b1111_1110;
    localparam logic [7:0] V_IMEM = 8'b0111_1100;
    localparam logic [7:0] V_MDU  = 8'b0001_1001;
    localparam logic [7:0] V_HOLD = 8'b0000_0000;

    pipeline_ctrl #(.CNT_W(16), .WAIT_LIMIT(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memread_id_ex (memread_id_ex),
        .rd_id_ex      (rd_id_ex),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .mdu_start     (mdu_start),
        .mdu_done      (mdu_done),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .ctrl_state    (ctrl_state),
        .stall_cycles  (stall_cycles),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread_id_ex = 1'b0;
        rd_id_ex      = 5'd0;
        rs1_id        = 5'd0;
        rs2_id        = 5'd0;
        branch_taken  = 1'b0;
        imem_ready    = 1'b1;
        dmem_req      = 1'b0;
        dmem_ready    = 1'b0;
        mdu_start     = 1'b0;
        mdu_done      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        #1;
        chk("rst_ctl", ctl, V_RST);
        chk("rst_state", ctrl_state, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_err", err_timeout, 0);

        rst_n = 1'b1;
        #1;
        chk("run_ctl", ctl, V_RUN);
        cyc();
        chk("run_stall", stall_cycles, 0);

        // load-use on rs1, then on rs2
        memread_id_ex = 1'b1; rd_id_ex = 5'd5; rs1_id = 5'd5;
        #1;
        chk("lu_rs1_ctl", ctl, V_LU);
        cyc();
        idle();
        #1;
        chk("lu_after_ctl", ctl, V_RUN);
        chk("lu_after_state", ctrl_state, 0);
        chk("lu_stall", stall_cycles, 1);
        memread_id_ex = 1'b1; rd_id_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7;
        #1;
        chk("lu_rs2_ctl", ctl, V_LU);
        cyc();
        idle();
        #1;
        chk("lu_rs2_stall", stall_cycles, 2);

        // x0 and non-load never stall
        memread_id_ex = 1'b1; rd_id_ex = 5'd0; rs1_id = 5'd0;
        #1;
        chk("lu_x0_ctl", ctl, V_RUN);
        cyc();
        memread_id_ex = 1'b0; rd_id_ex = 5'd5; rs1_id = 5'd5;
        #1;
        chk("lu_noload_ctl", ctl, V_RUN);
        cyc();
        chk("nolu_stall", stall_cycles, 2);

        // branch beats load-use and imem wait
        memread_id_ex = 1'b1; rd_id_ex = 5'd5; rs1_id = 5'd5;
        branch_taken = 1'b1;
        #1;
        chk("br_lu_ctl", ctl, V_BR);
        cyc();
        chk("br_stall", stall_cycles, 2);
        idle();
        branch_taken = 1'b1; imem_ready = 1'b0;
        #1;
        chk("br_imem_ctl", ctl, V_BR);
        cyc();
        idle();
        imem_ready = 1'b0;
        #1;
        chk("imem_ctl", ctl, V_IMEM);
        cyc();
        idle();
        #1;
        chk("imem_stall", stall_cycles, 3);

        // MUL/DIV: start, done four cycles later
        mdu_start = 1'b1;
        #1;
        chk("mdu_c0_ctl", ctl, V_MDU);
        chk("mdu_c0_state", ctrl_state, 0);
        cyc();
        mdu_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("mdu_busy_ctl", ctl, V_MDU);
            chk("mdu_busy_state", ctrl_state, 2);
            cyc();
        end
        mdu_done = 1'b1;
        #1;
        chk("mdu_done_ctl", ctl, V_RUN);
        chk("mdu_done_state", ctrl_state, 2);
        cyc();
        mdu_done = 1'b0;
        #1;
        chk("mdu_exit_state", ctrl_state, 0);
        chk("mdu_exit_ctl", ctl, V_RUN);
        chk("mdu_stall", stall_cycles, 7);

        // MUL/DIV interrupted by a dmem stall, result arrives meanwhile
        mdu_start = 1'b1;
        cyc();
        mdu_start = 1'b0;
        dmem_req = 1'b1;
        #1;
        chk("mm_c1_state", ctrl_state, 2);
        chk("mm_c1_ctl", ctl, V_HOLD);
        cyc();
        mdu_done = 1'b1;
        #1;
        chk("mm_c2_state", ctrl_state, 1);
        chk("mm_c2_ctl", ctl, V_HOLD);
        cyc();
        mdu_done = 1'b0;
        #1;
        chk("mm_c3_state", ctrl_state, 1);
        chk("mm_c3_ctl", ctl, V_HOLD);
        cyc();
        dmem_ready = 1'b1;
        #1;
        chk("mm_c4_state", ctrl_state, 1);
        chk("mm_c4_ctl", ctl, V_RUN);
        cyc();
        idle();
        #1;
        chk("mm_c5_state", ctrl_state, 0);
        chk("mm_stall", stall_cycles, 11);

        // watchdog: dmem_ready low for 70 cycles
        dmem_req = 1'b1;
        #1;
        chk("wd_c0_ctl", ctl, V_HOLD);
        for (int i = 0; i < 64; i++) cyc();
        chk("wd_63_err", err_timeout, 0);
        chk("wd_63_state", ctrl_state, 1);
        cyc();
        chk("wd_64_err", err_timeout, 1);
        for (int i = 0; i < 5; i++) cyc();
        chk("wd_69_err", err_timeout, 1);
        chk("wd_69_state", ctrl_state, 1);
        dmem_ready = 1'b1;
        #1;
        chk("wd_rel_ctl", ctl, V_RUN);
        cyc();
        idle();
        #1;
        chk("wd_rel_state", ctrl_state, 0);
        chk("wd_rel_err", err_timeout, 1);
        chk("wd_stall", stall_cycles, 81);

        // reset in the middle of a memory wait
        dmem_req = 1'b1;
        cyc();
        chk("rw_state", ctrl_state, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ctl", ctl, V_RST);
        cyc();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rw_state_run", ctrl_state, 0);
        chk("rw_err", err_timeout, 0);
        chk("rw_stall", stall_cycles, 0);
        chk("rw_ctl", ctl, V_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
